riscof_obi_periph: RTL

- Parametrised memory-mapped pseudo-peripheral for the RISCOF CV32E40P bench.
- Sits on the core data OBI port beside the RAM, decoded by BASE_ADDR.
- Provides multi-channel buffered stdout, an exit/pass/fail register, a cycle counter and a watchdog timeout.
- Replaces the fixed, unbuffered, single-channel stdout and exit logic of the previous bench generation.

---
 rtl/riscof_periph_pkg.sv | 20 ++
 rtl/riscof_byte_fifo.sv | 51 +++++
 rtl/riscof_obi_periph.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscof_periph_pkg.sv
// Shared definitions for the RISCOF OBI pseudo-peripheral: register offsets,
// status magic values and the response-pipe entry type.
package riscof_periph_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [7:0] STDOUT_OFS = 8'h00;
  localparam logic [7:0] EXIT_OFS   = 8'h40;
  localparam logic [7:0] STATUS_OFS = 8'h44;
  localparam logic [7:0] CYCLE_OFS  = 8'h48;

  localparam logic [DATA_W-1:0] PASS_MAGIC = 32'd123456789;
  localparam logic [DATA_W-1:0] FAIL_MAGIC = 32'd1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/riscof_byte_fifo.sv
// Byte FIFO for one stdout channel; accepts a push while full if a pop
// happens in the same cycle, no bypass from push to head.
module riscof_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [7:0]               head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = count;
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the level gates visibility of stale bytes.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/riscof_obi_periph.sv
// RISCOF bench pseudo-peripheral on the data OBI port: buffered multi-channel
// stdout, exit/pass/fail registers, a cycle counter and a watchdog.
module riscof_obi_periph
  import riscof_periph_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned RVALID_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0001
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic [NUM_CHANNELS-1:0]   char_valid_o,
  output logic [8*NUM_CHANNELS-1:0] char_data_o,
  input  logic [NUM_CHANNELS-1:0]   char_ready_i,
  output logic                      exit_valid_o,
  output logic [31:0]               exit_value_o,
  output logic                      tests_passed_o,
  output logic                      tests_failed_o,
  output logic                      timeout_o,
  output logic                      decode_err_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                    hit;
  logic [7:0]              ofs;
  logic [NUM_CHANNELS-1:0] sel_ch, full, empty, pop, push;
  logic [LW-1:0]           level [NUM_CHANNELS];
  logic [7:0]              head  [NUM_CHANNELS];
  logic                    is_exit, is_status, is_cycle, mapped;
  logic                    stall, gnt, exit_wr, status_wr;
  logic                    wd_en, wd_fire;
  logic [31:0]             wd_cnt, cycle_cnt, rd_mux;
  resp_t                   pipe [RVALID_LATENCY];
  logic                    unused_bits;

  assign unused_bits = ^{addr_i[1:0], be_i[3:1]};

  assign hit       = (addr_i[31:8] == BASE_ADDR[31:8]);
  assign ofs       = {addr_i[7:2], 2'b00};
  assign is_exit   = (ofs == EXIT_OFS);
  assign is_status = (ofs == STATUS_OFS);
  assign is_cycle  = (ofs == CYCLE_OFS);
  assign mapped    = (|sel_ch) || is_exit || is_status || is_cycle;

  // Only a write into a full, non-draining channel may hold off the grant.
  assign stall        = we_i && |(sel_ch & full & ~pop);
  assign gnt          = !rst_i && req_i && hit && !stall;
  assign gnt_o        = gnt;
  assign decode_err_o = gnt && !mapped;
  assign exit_wr      = gnt && we_i && is_exit;
  assign status_wr    = gnt && we_i && is_status;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign sel_ch[c]           = (ofs == STDOUT_OFS + 8'(4 * c));
    assign pop[c]              = !empty[c] && char_ready_i[c];
    assign push[c]             = gnt && we_i && be_i[0] && sel_ch[c];
    assign char_valid_o[c]     = !empty[c];
    assign char_data_o[8*c +: 8] = empty[c] ? 8'h00 : head[c];

    riscof_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[c]),
      .data_i  (wdata_i[7:0]),
      .pop_i   (pop[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .level_o (level[c]),
      .head_o  (head[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sel_ch[c]) rd_mux = 32'(level[c]);
    end
    if (is_exit)   rd_mux = exit_value_o;
    if (is_status) rd_mux = {29'b0, timeout_o, tests_failed_o, tests_passed_o};
    if (is_cycle)  rd_mux = cycle_cnt;
  end

  // Response pipe: read data is captured at grant time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RVALID_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: gnt, rdata: (gnt && !we_i) ? rd_mux : 32'h0};
      for (int i = 1; i < RVALID_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rvalid_o = pipe[RVALID_LATENCY-1].valid;
  assign rdata_o  = pipe[RVALID_LATENCY-1].rdata;

  assign wd_en   = (TIMEOUT_CYCLES != 0) && !exit_valid_o;
  assign wd_fire = wd_en && (wd_cnt == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wd_en) wd_cnt <= wd_cnt + 32'd1;
    end
  end

  // An EXIT write in the firing cycle takes precedence over the watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      if (exit_wr) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= wdata_i;
      end else if (wd_fire) begin
        exit_valid_o   <= 1'b1;
        exit_value_o   <= TIMEOUT_CODE;
        timeout_o      <= 1'b1;
        tests_failed_o <= 1'b1;
      end
      if (status_wr && wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
      if (status_wr && wdata_i == FAIL_MAGIC) tests_failed_o <= 1'b1;
    end
  end

endmodule
